// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch front-end.
package pipe_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INS  = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000;

    // One prefetch queue entry: the instruction and the address after it.
    typedef struct packed {
        logic [INSTR_W-1:0] ins;
        logic [ADDR_W-1:0]  pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory port and IF/ID delivery port of the fetch unit.
//
// Handshakes: a transfer happens on a rising clock edge where the sender's
// valid (imem_req / out_valid) and the receiver's ready (imem_gnt / out_ready)
// are both high. The sender keeps valid and its payload stable until that
// edge, except that a redirect may withdraw an ungranted request.
// imem_rvalid has no ready: responses are always accepted, in request order.
interface fetch_unit_if;
    import pipe_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_ins;
    logic [ADDR_W-1:0]  out_pc4;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output out_valid, out_ins, out_pc4,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  out_valid, out_ins, out_pc4,
        output out_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of {ins, pc4} entries; flush beats push.
module fetch_queue import pipe_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue may still take a push when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; a flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: issues in-order word reads, buffers returned
// instructions in a prefetch queue and hands them to IF/ID with their PC+4.
module fetch_unit #(
    parameter logic [pipe_pkg::ADDR_W-1:0] RESET_PC  = pipe_pkg::RESET_PC,
    parameter int                          DEPTH     = 4,
    parameter int                          MAX_OUTST = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    fetch_unit_if.master                bus,
    input  logic                        redirect_valid,
    input  logic [pipe_pkg::ADDR_W-1:0] redirect_pc
);
    import pipe_pkg::*;

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int QW = $clog2(DEPTH) + 1;
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic              run;
    logic [ADDR_W-1:0] fetch_pc;
    logic [OW-1:0]     outst;
    logic [OW-1:0]     discard;
    logic [ADDR_W-1:0] pcf_mem [MAX_OUTST];
    logic [PW-1:0]     pcf_wr;
    logic [PW-1:0]     pcf_rd;

    logic              issue;
    logic              granted;
    logic              rsp;
    logic              keep;
    logic              pop;
    logic [QW-1:0]     q_count;
    logic              q_full;
    logic              q_empty;
    fetch_entry_t      q_wdata;
    fetch_entry_t      q_rdata;

    // Occupancy counts in-flight reads too, so a returning word always has room.
    assign issue   = run && !redirect_valid
                     && ((int'(q_count) + int'(outst)) < DEPTH)
                     && (int'(outst) < MAX_OUTST);
    assign granted = issue && bus.imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp     = bus.imem_rvalid && (outst != '0);
    assign keep    = rsp && (discard == '0) && !redirect_valid;
    assign pop     = !q_empty && bus.out_ready;
    assign q_wdata = '{ins: bus.imem_rdata, pc4: pcf_mem[pcf_rd]};

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = !q_empty;
    assign bus.out_ins   = q_empty ? NOP_INS : q_rdata.ins;
    assign bus.out_pc4   = q_empty ? '0 : q_rdata.pc4;

    // Fetch address, request enable and the outstanding/discard counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            outst    <= '0;
            discard  <= '0;
        end else begin
            run   <= 1'b1;
            outst <= outst + OW'(granted) - OW'(rsp);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~32'h3;
                // Every read still in flight after this edge belongs to the old path.
                discard  <= outst - OW'(rsp);
            end else begin
                if (granted) fetch_pc <= fetch_pc + 32'd4;
                if (rsp && (discard != '0)) discard <= discard - OW'(1);
            end
        end
    end

    // In-flight PC FIFO pointers: one entry per granted read, freed by its response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_wr <= '0;
            pcf_rd <= '0;
        end else begin
            if (granted) pcf_wr <= (pcf_wr == PW'(MAX_OUTST - 1)) ? '0 : pcf_wr + PW'(1);
            if (rsp)     pcf_rd <= (pcf_rd == PW'(MAX_OUTST - 1)) ? '0 : pcf_rd + PW'(1);
        end
    end

    // In-flight PC FIFO storage holding the PC+4 of each granted read.
    always_ff @(posedge clk) begin
        if (granted) pcf_mem[pcf_wr] <= fetch_pc + 32'd4;
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (keep),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) bus.imem_rvalid |-> (outst != '0));

    queue_never_overflows: assert property (
        @(posedge clk) disable iff (!rst_n) keep |-> (!q_full || pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, IF/ID sink with an
// expected-PC scoreboard, a redirect vector table and hand-written sequences.
module tb_fetch_unit;
    import pipe_pkg::*;

    localparam int DEPTH     = 4;
    localparam int MAX_OUTST = 2;

    typedef struct {
        logic [31:0] rpc;       // redirect target as driven
        logic [31:0] exp_addr;  // first fetch address after the redirect
        logic [31:0] exp_pc4;   // first out_pc4 and second fetch address
    } redir_vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    logic        gnt_en = 1'b1;
    int          gnt_mod = 0;       // 0: grant always; N: no grant when cyc%N==0
    logic [31:0] mem_q[$];
    int          due_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] gen_pc = '0;
    logic [31:0] gq[$];
    int          pops = 0;
    logic [31:0] last_pc4 = '0;
    logic        held_req = 1'b0;
    logic [31:0] held_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(input logic rdr, input logic [31:0] rpc, input logic rdy);
        logic [31:0] e;
        @(negedge clk);
        if (mem_q.size() > 0 && due_q[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(mem_q[0]);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
        bus.imem_gnt   = gnt_en && !(gnt_mod != 0 && (cyc % gnt_mod) == 0);
        redirect_valid = rdr;
        redirect_pc    = rpc;
        bus.out_ready  = rdy;
        #1;
        if (rdr) check("no_req_in_redirect", 32'(bus.imem_req), 32'd0);
        if (held_req && !rdr) begin
            check("req_held", 32'(bus.imem_req), 32'd1);
            check("addr_held", bus.imem_addr, held_addr);
        end
        // scoreboard: IF/ID consumes the head
        if (bus.out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                exp_q.push_back(gen_pc);
                gen_pc += 32'd4;
            end
            e = exp_q.pop_front();
            check("out_pc4", bus.out_pc4, e + 32'd4);
            check("out_ins", bus.out_ins, mem_word(e));
            pops++;
            last_pc4 = bus.out_pc4;
        end
        if (rdr) begin
            exp_q.delete();
            gen_pc = rpc & ~32'h3;
        end
        // memory model
        if (bus.imem_rvalid) begin
            void'(mem_q.pop_front());
            void'(due_q.pop_front());
        end
        held_req  = bus.imem_req && !bus.imem_gnt;
        held_addr = bus.imem_addr;
        if (bus.imem_req && bus.imem_gnt) begin
            mem_q.push_back(bus.imem_addr);
            due_q.push_back(cyc + lat);
            gq.push_back(bus.imem_addr);
        end
        cyc++;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_ins", bus.out_ins, 32'h0);
        check("rst_pc4", bus.out_pc4, 32'h0);
        mem_q.delete();
        due_q.delete();
        exp_q.delete();
        gq.delete();
        gen_pc          = 32'h0;
        held_req        = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        redirect_valid  = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("req_waits_for_edge", 32'(bus.imem_req), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    redir_vec_t vecs[5];

    initial begin
        int guard;
        int gi;
        int p0;

        vecs[0] = '{rpc: 32'h0000_0040, exp_addr: 32'h0000_0040, exp_pc4: 32'h0000_0044};
        vecs[1] = '{rpc: 32'h0000_0103, exp_addr: 32'h0000_0100, exp_pc4: 32'h0000_0104};
        vecs[2] = '{rpc: 32'hFFFF_FFFC, exp_addr: 32'hFFFF_FFFC, exp_pc4: 32'h0000_0000};
        vecs[3] = '{rpc: 32'h0000_1002, exp_addr: 32'h0000_1000, exp_pc4: 32'h0000_1004};
        vecs[4] = '{rpc: 32'h7FFF_FFF1, exp_addr: 32'h7FFF_FFF0, exp_pc4: 32'h7FFF_FFF4};

        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.out_ready   = 1'b0;

        // Test 1: reset, 1-cycle memory, always ready
        async_reset();
        lat = 1;
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
        check("t1_grants", 32'(gq.size() >= 3), 32'd1);
        if (gq.size() >= 3) begin
            check("t1_addr0", gq[0], 32'h0);
            check("t1_addr1", gq[1], 32'h4);
            check("t1_addr2", gq[2], 32'h8);
        end
        check("t1_throughput", 32'(pops >= 12), 32'd1);

        // Test 6 then 2: async reset mid-stream, then stall until the queue fills
        async_reset();
        pops = 0;
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0);
        check("t2_valid_full", 32'(bus.out_valid), 32'd1);
        check("t2_req_dropped", 32'(bus.imem_req), 32'd0);
        check("t2_grants", 32'(gq.size()), 32'd4);
        check("t2_no_pops", 32'(pops), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        check("t2_pops", 32'(pops), 32'd4);
        check("t2_last_pc4", last_pc4, 32'h10);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
        check("t2_resume", 32'(gq.size() > 4), 32'd1);
        if (gq.size() > 4) check("t2_resume_addr", gq[4], 32'h10);

        // Redirect table: 3-cycle memory, redirect with two reads in flight
        // and a response arriving in the redirect cycle
        lat = 3;
        for (int v = 0; v < 5; v++) begin
            guard = 0;
            while (!(mem_q.size() == 2 && due_q[0] <= cyc) && guard < 30) begin
                cycle(1'b0, '0, 1'b1);
                guard++;
            end
            check("rd_setup_timeout", 32'(guard < 30), 32'd1);
            cycle(1'b1, vecs[v].rpc, 1'b1);
            gi = gq.size();
            p0 = pops;
            cycle(1'b0, '0, 1'b1);
            check("rd_valid_low", 32'(bus.out_valid), 32'd0);
            check("rd_req", 32'(bus.imem_req), 32'd1);
            check("rd_addr", bus.imem_addr, vecs[v].exp_addr);
            guard = 0;
            while (pops == p0 && guard < 30) begin
                cycle(1'b0, '0, 1'b1);
                guard++;
            end
            check("rd_first_pop_timeout", 32'(guard < 30), 32'd1);
            check("rd_first_pc4", last_pc4, vecs[v].exp_pc4);
            check("rd_grants", 32'(gq.size() > gi + 1), 32'd1);
            if (gq.size() > gi + 1) check("rd_next_addr", gq[gi + 1], vecs[v].exp_pc4);
        end

        // Back-to-back redirects: the last one wins
        cycle(1'b1, 32'h0000_0200, 1'b1);
        cycle(1'b1, 32'h0000_0300, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("b2b_valid_low", 32'(bus.out_valid), 32'd0);
        check("b2b_addr", bus.imem_addr, 32'h300);
        p0 = pops;
        guard = 0;
        while (pops == p0 && guard < 30) begin
            cycle(1'b0, '0, 1'b1);
            guard++;
        end
        check("b2b_pop_timeout", 32'(guard < 30), 32'd1);
        check("b2b_first_pc4", last_pc4, 32'h304);

        // Intermittent grant and back-pressure: request must hold until granted
        lat = 2;
        gnt_mod = 3;
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, logic'(i % 4 != 1));
        gnt_mod = 0;
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);

        // Redirect while a head is being consumed and the queue is non-empty
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
        check("pre_redirect_valid", 32'(bus.out_valid), 32'd1);
        p0 = pops;
        cycle(1'b1, 32'h0000_0800, 1'b1);
        check("redirect_pop_counted", 32'(pops), 32'(p0 + 1));
        cycle(1'b0, '0, 1'b1);
        check("post_redirect_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1);
        check("post_redirect_stream", 32'(last_pc4 > 32'h804), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
